// File: rtl/reg_bank_pkg.sv
// Shared constants and address-width helpers for the reg_bank register file.
package reg_bank_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREGS = 4;
    localparam logic [DEF_WIDTH-1:0] DEF_RESET_VAL = '0;

    function automatic int clog2(input int n);
        int bits;
        bits = 0;
        for (int v = 1; v < n; v = v << 1) begin
            bits++;
        end
        return bits;
    endfunction

    // A single-register bank still needs a one-bit address port.
    function automatic int addr_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// One register of the bank: reset, then write, clear and set applied in that order.
module reg_bank_cell
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_hit,
    input  logic             clr_hit,
    input  logic             set_hit,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] clr_mask,
    input  logic [WIDTH-1:0] set_mask,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_next
);

    logic [WIDTH-1:0] value_reg;

    // Set is applied last so it wins over both write and clear on a shared bit.
    always_comb begin
        value_next = value_reg;
        if (wr_hit) begin
            value_next = wdata;
        end
        if (clr_hit) begin
            value_next = value_next & ~clr_mask;
        end
        if (set_hit) begin
            value_next = value_next | set_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_reg <= RESET_VAL;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/reg_bank.sv
// Register bank with word write, set/clear masks, two registered read ports and nz flags.
// Define REG_BANK_BYPASS_EN to make reads capture the post-update (write-through) value.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
    localparam int AW = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic [WIDTH-1:0] set_mask,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic [WIDTH-1:0] clr_mask,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic [NREGS-1:0] nz
);

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0] cur_val  [NREGS];
    logic [WIDTH-1:0] next_val [NREGS];
    logic [WIDTH-1:0] read_src [NREGS];

    logic [WIDTH-1:0] rdata0_reg, rdata0_next;
    logic [WIDTH-1:0] rdata1_reg, rdata1_next;
    logic [NREGS-1:0] nz_reg, nz_next;

    // Addresses >= NREGS match no cell, so those requests fall away naturally.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_cell
            logic wr_hit, clr_hit, set_hit;
            assign wr_hit  = we     && (waddr    == AW'(gi));
            assign clr_hit = clr_en && (clr_addr == AW'(gi));
            assign set_hit = set_en && (set_addr == AW'(gi));

            reg_bank_cell #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_cell (
                .clk        (clk),
                .rst        (rst),
                .wr_hit     (wr_hit),
                .clr_hit    (clr_hit),
                .set_hit    (set_hit),
                .wdata      (wdata),
                .clr_mask   (clr_mask),
                .set_mask   (set_mask),
                .value      (cur_val[gi]),
                .value_next (next_val[gi])
            );

            assign read_src[gi] = BYPASS ? next_val[gi] : cur_val[gi];
            assign nz_next[gi]  = |next_val[gi];
        end
    endgenerate

    // Read muxes default to zero so out-of-range addresses return 0.
    always_comb begin
        rdata0_next = '0;
        rdata1_next = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (raddr0 == AW'(r)) begin
                rdata0_next = read_src[r];
            end
            if (raddr1 == AW'(r)) begin
                rdata1_next = read_src[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata0_reg <= '0;
            rdata1_reg <= '0;
            nz_reg     <= {NREGS{RESET_VAL != '0}};
        end else begin
            rdata0_reg <= rdata0_next;
            rdata1_reg <= rdata1_next;
            nz_reg     <= nz_next;
        end
    end

    assign rdata0 = rdata0_reg;
    assign rdata1 = rdata1_reg;
    assign nz     = nz_reg;

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised bank of NREGS registers, WIDTH bits each, for the neural-net processor datapath.
- Generalises the single enable/reset register and the SR latch into one synchronous block: per-cycle word write, bitwise set-mask and clear-mask updates, and two registered read ports.
- Per-register non-zero status flags feed the processor control logic.

Parameters:
- WIDTH, 8, bits per register (>=1).
- NREGS, 4, number of registers (>=2; need not be a power of 2).
- RESET_VAL, 0, value loaded into every register on reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low.
- we  input  1  word write enable.
- waddr  input  AW  write address; AW = max(1, clog2(NREGS)).
- wdata  input  WIDTH  write data.
- set_en  input  1  bitwise set enable.
- set_addr  input  AW  set target register.
- set_mask  input  WIDTH  bits to force to 1.
- clr_en  input  1  bitwise clear enable.
- clr_addr  input  AW  clear target register.
- clr_mask  input  WIDTH  bits to force to 0.
- raddr0, raddr1  input  AW  read addresses.
- rdata0, rdata1  output  WIDTH  registered read data.
- nz  output  NREGS  bit r = 1 when register r is non-zero (registered).

Behaviour:
- Reset: on a posedge with rst=0, every register is set to RESET_VAL. rdata0 and rdata1 are set to 0. nz[r] is set to (RESET_VAL != 0) for all r. All other inputs are ignored that cycle.
- Reset asserted mid-operation discards all same-cycle write, set and clear requests.
- Per-register next value, evaluated in this fixed order:
  - v = (we && waddr==r) ? wdata : cur
  - v = (clr_en && clr_addr==r) ? v & ~clr_mask : v
  - v = (set_en && set_addr==r) ? v | set_mask : v
  - Consequences: clear overrides a write; set overrides both write and clear on the same bit. There is no forbidden state, unlike the NOR latch.
- Write, set and clear may target the same or different registers in one cycle. All updates take effect on the same edge.
- Out-of-range addresses (>= NREGS):
  - Write, set and clear requests to such an address are ignored.
  - A read from such an address returns 0.
- Reads: rdataN is registered from raddrN, so the latency is 1 cycle. Data is always available; there is no handshake.
- Read value without the optional feature is the register content before the same-edge update.
- nz is registered from the post-update register values, so it tracks the registers with no extra latency.
- Disabled cycle (we=set_en=clr_en=0): all registers hold their value. Reads still update.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined: write-through forwarding. rdataN captures the post-update value of register raddrN, i.e. the value after this edge's write, clear and set. A read then sees same-cycle writes one cycle after issue.
- Undefined: rdataN captures the pre-update value. A read issued in the same cycle as a write returns the old contents.
- Out-of-range reads return 0 in both modes.

Decomposition:
- Package reg_bank_pkg holds:
  - clog2 function and the AW derivation rule.
  - Default WIDTH, NREGS and RESET_VAL constants.
- Sub-module reg_bank_cell: one WIDTH-bit register implementing reset, write, clear and set in the fixed priority above.
  - Inputs: hit flags and shared data/masks.
  - Outputs: current and next value (next is used for bypass and for nz).
- Top level: instantiates NREGS cells, address decode, two read muxes and the output registers.

Test Plan:
- Reset: RESET_VAL=0x00, hold rst=0 for 2 clk, then release -> all registers read 0x00, rdata0=rdata1=0, nz=4'b0000.
- Write/read: we=1, waddr=2, wdata=0xA5; next cycle raddr0=2 -> rdata0=0xA5 one cycle later, nz=4'b0100.
- Priority: reg1=0x0F; in one cycle we=1 wdata=0xFF, clr_mask=0xF0, set_mask=0x81, all addressed to reg1 -> reg1=0x8F.
- Same-cycle read/write: reg3=0x11; write 0x22 to reg3 with raddr1=3 in the same cycle -> rdata1=0x11 without REG_BANK_BYPASS_EN, 0x22 with it.
- Out-of-range (NREGS=3, AW=2): write 0x55 to addr 3 -> no register changes, nz unchanged; raddr0=3 -> rdata0=0x00.
- Mid-operation reset: rst=0 in the same cycle as we=1 waddr=0 wdata=0x33 -> reg0=RESET_VAL, rdata0=0, write discarded.
